// File: rtl/vram_dbg_pkg.sv
// Shared definitions for the VRAM debugger engines: FSM encoding, transfer
// mode constants, error-counter width and image ROM extent.
package vram_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REQ   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic MODE_COPY   = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;

  localparam int ERR_W = 16;

  // Number of bytes that actually carry image content; reads past this are 0.
  localparam int IMG_ROM_WORDS = 16384;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vram_image_rom_p.sv
// Built-in image ROM: case-table contents with a registered output so it maps
// onto block RAM. Addresses beyond the stored image read back as zero.
module vram_image_rom_p
  import vram_dbg_pkg::*;
#(
  parameter int ADR_W = 14,
  parameter int DAT_W = 8
) (
  input  logic             clk,
  input  logic [ADR_W-1:0] adr,
  output logic [DAT_W-1:0] q
);

  // Image table: a fixed header followed by a generated test pattern.
  function automatic logic [DAT_W-1:0] image_byte(input logic [ADR_W-1:0] a);
    int         ai;
    logic [7:0] b;
    ai = 32'(a);
    b  = 8'h00;
    if (ai < IMG_ROM_WORDS) begin
      case (ai)
        0:       b = 8'h3C;
        1:       b = 8'hA5;
        2:       b = 8'h5A;
        3:       b = 8'hC3;
        4:       b = 8'h0F;
        5:       b = 8'hF0;
        6:       b = 8'h81;
        7:       b = 8'h7E;
        default: b = ai[7:0] ^ ai[13:6];
      endcase
    end
    return DAT_W'(b);
  endfunction

  // Registered read: data appears one clock after the address.
  always_ff @(posedge clk) begin
    q <= image_byte(adr);
  end

endmodule

// File: rtl/vram_image_loader.sv
// Streams the image ROM into VRAM (COPY) or reads VRAM back and counts bytes
// that differ from the image (VERIFY), over a req/ack arbiter port.
// Each transfer is FETCH (ROM address), REQ load cycle (ROM data now valid,
// request registers loaded), then request held until acknowledged.
module vram_image_loader
  import vram_dbg_pkg::*;
#(
  parameter int ADR_W   = 14,
  parameter int DAT_W   = 8,
  parameter int IMG_LEN = 16384,
  parameter int VADR_W  = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              verify,
  input  logic [VADR_W-1:0] base_adr,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              vram_req,
  output logic              vram_wr,
  output logic [VADR_W-1:0] vram_adr,
  output logic [DAT_W-1:0]  vram_wdata,
  input  logic              vram_ack,
  input  logic [DAT_W-1:0]  vram_rdata
);

  localparam int SUM_W = (VADR_W > ADR_W) ? VADR_W : ADR_W;
  localparam logic [ADR_W-1:0] LAST_IDX = ADR_W'(IMG_LEN - 1);

  state_t              state_reg,      state_next;
  logic [ADR_W-1:0]    idx_reg,        idx_next;
  logic                verify_reg,     verify_next;
  logic [VADR_W-1:0]   base_reg,       base_next;
  logic                busy_reg,       busy_next;
  logic                done_reg,       done_next;
  logic [ERR_W-1:0]    err_cnt_reg,    err_cnt_next;
  logic                vram_req_reg,   vram_req_next;
  logic                vram_wr_reg,    vram_wr_next;
  logic [VADR_W-1:0]   vram_adr_reg,   vram_adr_next;
  logic [DAT_W-1:0]    vram_wdata_reg, vram_wdata_next;

  logic [DAT_W-1:0]    rom_q;
  logic [SUM_W-1:0]    adr_sum;
  logic [VADR_W-1:0]   req_adr;
  logic                last_xfer;
  logic                mismatch;

  vram_image_rom_p #(
    .ADR_W (ADR_W),
    .DAT_W (DAT_W)
  ) u_rom (
    .clk (clk),
    .adr (idx_reg),
    .q   (rom_q)
  );

  // Target address wraps silently at the top of VRAM.
  assign adr_sum   = SUM_W'(base_reg) + SUM_W'(idx_reg);
  assign req_adr   = adr_sum[VADR_W-1:0];
  assign last_xfer = (idx_reg == LAST_IDX);
  // ROM address is idx, which is stable throughout REQ, so rom_q is the reference byte.
  assign mismatch  = (verify_reg == MODE_VERIFY) && (vram_rdata != rom_q);

  // State and datapath registers; reset drops every output immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      verify_reg     <= MODE_COPY;
      base_reg       <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_cnt_reg    <= '0;
      vram_req_reg   <= 1'b0;
      vram_wr_reg    <= 1'b0;
      vram_adr_reg   <= '0;
      vram_wdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      verify_reg     <= verify_next;
      base_reg       <= base_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_cnt_reg    <= err_cnt_next;
      vram_req_reg   <= vram_req_next;
      vram_wr_reg    <= vram_wr_next;
      vram_adr_reg   <= vram_adr_next;
      vram_wdata_reg <= vram_wdata_next;
    end
  end

  // Next-state and output logic; abort overrides whatever the state decided.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    verify_next     = verify_reg;
    base_next       = base_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    err_cnt_next    = err_cnt_reg;
    vram_req_next   = vram_req_reg;
    vram_wr_next    = vram_wr_reg;
    vram_adr_next   = vram_adr_reg;
    vram_wdata_next = vram_wdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          verify_next  = verify;
          base_next    = base_adr;
          idx_next     = '0;
          err_cnt_next = '0;
          busy_next    = 1'b1;
          state_next   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        if (!vram_req_reg) begin
          // Load cycle: ROM data has just become valid.
          vram_req_next   = 1'b1;
          vram_adr_next   = req_adr;
          vram_wr_next    = (verify_reg == MODE_COPY);
          vram_wdata_next = rom_q;
        end else if (vram_ack) begin
          vram_req_next = 1'b0;
          if (mismatch) begin
            err_cnt_next = sat_inc(err_cnt_reg);
          end
          if (last_xfer) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = ST_FIN;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_next    = ST_IDLE;
      vram_req_next = 1'b0;
      busy_next     = 1'b0;
      done_next     = 1'b0;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err_cnt    = err_cnt_reg;
  assign vram_req   = vram_req_reg;
  assign vram_wr    = vram_wr_reg;
  assign vram_adr   = vram_adr_reg;
  assign vram_wdata = vram_wdata_reg;

endmodule

// File: tb/tb_vram_image_loader.sv
// Bench for vram_image_loader with a 4-byte image: table of runs plus
// hand-written abort / ignored-start / saturation / async-reset sequences.
module tb_vram_image_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        verify = 1'b0;
  logic [16:0] base_adr = '0;
  logic        busy, done;
  logic [15:0] err_cnt;
  logic        vram_req, vram_wr;
  logic [16:0] vram_adr;
  logic [7:0]  vram_wdata;
  logic        vram_ack = 1'b0;
  logic [7:0]  vram_rdata = '0;

  vram_image_loader #(
    .ADR_W   (14),
    .DAT_W   (8),
    .IMG_LEN (4),
    .VADR_W  (17)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .verify     (verify),
    .base_adr   (base_adr),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .vram_req   (vram_req),
    .vram_wr    (vram_wr),
    .vram_adr   (vram_adr),
    .vram_wdata (vram_wdata),
    .vram_ack   (vram_ack),
    .vram_rdata (vram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        verify;
    logic [16:0] base;
    int          delay_idx;
    int          delay;
    logic [3:0]  flip_mask;
    logic [7:0]  flip_val;
    logic        ack_idle;
    int          inject_at;
    logic [15:0] exp_err;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic [16:0] adr;
    logic        wr;
    logic [7:0]  wdata;
  } xfer_t;

  logic [7:0] rom_exp [4] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};

  xfer_t sb[$];
  vec_t  vecs[5];
  int    checks = 0;
  int    passed = 0;

  int         cfg_delay_idx = -1;
  int         cfg_delay = 0;
  logic [3:0] cfg_flip_mask = '0;
  logic [7:0] cfg_flip_val = '0;
  logic       cfg_ack_idle = 1'b0;
  int         wait_cnt = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // VRAM responder and scoreboard: checks every request cycle against the
  // head of the queue, pops on the acknowledged cycle.
  initial begin
    int need;
    int idx;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (vram_req) begin
        idx = xfer_cnt % 4;
        vram_rdata = rom_exp[idx] ^ (cfg_flip_mask[idx] ? cfg_flip_val : 8'h00);
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk("req_adr", 32'(vram_adr), 32'(sb[0].adr));
          chk("req_wr", 32'(vram_wr), 32'(sb[0].wr));
          chk("req_wdata", 32'(vram_wdata), 32'(sb[0].wdata));
        end
        need = (xfer_cnt == cfg_delay_idx) ? cfg_delay : 0;
        if (wait_cnt >= need) begin
          vram_ack = 1'b1;
          $display("  xfer %0d adr=%h wr=%b wdata=%h rdata=%h waited=%0d",
                   xfer_cnt, vram_adr, vram_wr, vram_wdata, vram_rdata, wait_cnt);
          if (sb.size() != 0) void'(sb.pop_front());
          xfer_cnt++;
          wait_cnt = 0;
        end else begin
          vram_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        vram_ack = cfg_ack_idle;
      end
    end
  end

  task automatic setup_run(input vec_t v);
    xfer_t e;
    cfg_delay_idx = v.delay_idx;
    cfg_delay     = v.delay;
    cfg_flip_mask = v.flip_mask;
    cfg_flip_val  = v.flip_val;
    cfg_ack_idle  = v.ack_idle;
    wait_cnt = 0;
    xfer_cnt = 0;
    done_cnt = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      e.adr   = v.base + 17'(i);
      e.wr    = ~v.verify;
      e.wdata = rom_exp[i];
      sb.push_back(e);
    end
    start    = 1'b1;
    verify   = v.verify;
    base_adr = v.base;
  endtask

  task automatic run_case(input vec_t v, input string name);
    int cyc;
    int bad;
    @(negedge clk);
    setup_run(v);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == v.inject_at) begin
        start = 1'b1;
        base_adr = 17'h0ABCD;
        verify = ~v.verify;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    chk({name, "_done_cycles"}, 32'(cyc), 32'(v.exp_cycles));
    chk({name, "_err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({name, "_xfer_count"}, 32'(xfer_cnt), 32'd4);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_done_width"}, 32'(done), 32'd0);
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (vram_req || busy) bad++;
    end
    chk({name, "_idle_after"}, 32'(bad), 32'd0);
    chk({name, "_err_hold"}, 32'(err_cnt), 32'(v.exp_err));
    $display("run %s: verify=%b base=%h cycles=%0d err_cnt=%h", name, v.verify, v.base, cyc, err_cnt);
  endtask

  initial begin
    vec_t v;
    int   bad;
    bit   got;
    int   cyc;

    vecs[0] = '{1'b0, 17'h1FFFE, -1, 0, 4'b0000, 8'h00, 1'b1, -1, 16'h0000, 12};
    vecs[1] = '{1'b1, 17'h00100, -1, 0, 4'b0100, 8'h01, 1'b1, -1, 16'h0001, 12};
    vecs[2] = '{1'b0, 17'h00040,  1, 5, 4'b0000, 8'h00, 1'b0,  5, 16'h0000, 17};
    vecs[3] = '{1'b1, 17'h1FFFF,  3, 2, 4'b1111, 8'h80, 1'b1, -1, 16'h0004, 14};
    vecs[4] = '{1'b1, 17'h00000, -1, 0, 4'b0000, 8'h00, 1'b0, 12, 16'h0000, 12};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_req", 32'(vram_req), 32'd0);
    chk("rst_wr", 32'(vram_wr), 32'd0);
    chk("rst_adr", 32'(vram_adr), 32'd0);
    chk("rst_wdata", 32'(vram_wdata), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_case(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort while idx2 is being requested (ack withheld)
    v = '{1'b1, 17'h00200, 2, 10, 4'b0001, 8'h10, 1'b0, -1, 16'h0000, 0};
    @(negedge clk);
    setup_run(v);
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (vram_req && vram_adr == 17'h00202) got = 1'b1;
    end
    chk("abort_reached_idx2", 32'(got), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_req_low", 32'(vram_req), 32'd0);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_xfers", 32'(xfer_cnt), 32'd2);
    chk("abort_err_partial", 32'(err_cnt), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_stays_idle", 32'(busy), 32'd0);
    sb.delete();
    $display("run abort: stopped after %0d transfers, err_cnt=%h", xfer_cnt, err_cnt);

    // start together with abort while idle: nothing happens
    start = 1'b1;
    abort = 1'b1;
    base_adr = 17'h05555;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || vram_req) bad++;
      @(negedge clk);
    end
    chk("start_abort_idle", 32'(bad), 32'd0);
    chk("start_abort_err_kept", 32'(err_cnt), 32'd1);
    chk("start_abort_xfers", 32'(xfer_cnt), 32'd2);
    $display("run start+abort: busy=%b err_cnt=%h", busy, err_cnt);

    // Fresh start after abort begins again at base+0
    v = '{1'b0, 17'h00300, -1, 0, 4'b0000, 8'h00, 1'b1, -1, 16'h0000, 12};
    run_case(v, "restart");

    // Saturation: preload the counter near full, then mismatch every byte
    v = '{1'b1, 17'h00700, -1, 0, 4'b1111, 8'hFF, 1'b0, -1, 16'hFFFF, 12};
    @(negedge clk);
    setup_run(v);
    @(negedge clk);
    start = 1'b0;
    force dut.err_cnt_reg = 16'hFFFD;
    @(negedge clk);
    release dut.err_cnt_reg;
    chk("sat_preload", 32'(err_cnt), 32'h0000FFFD);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("sat_done_seen", 32'(done), 32'd1);
    chk("sat_err_cnt", 32'(err_cnt), 32'h0000FFFF);
    chk("sat_xfers", 32'(xfer_cnt), 32'd4);
    $display("run saturate: err_cnt=%h", err_cnt);

    // Asynchronous reset in the middle of a run
    v = '{1'b1, 17'h00400, 1, 6, 4'b0000, 8'h00, 1'b0, -1, 16'h0000, 0};
    @(negedge clk);
    setup_run(v);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_req_before", 32'(vram_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req", 32'(vram_req), 32'd0);
    chk("midrst_adr", 32'(vram_adr), 32'd0);
    chk("midrst_wdata", 32'(vram_wdata), 32'd0);
    chk("midrst_err", 32'(err_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    $display("run mid-run reset: outputs cleared");

    run_case(vecs[0], "after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
